// File: rtl/writeback_queue.sv
//-----------------------------------------------------------------------------
// writeback_queue
//
// Small in-order FIFO between the ALU / load result paths and the register
// file write port. Accepts at most one result per cycle (loads win over ALU
// results) and retires the head entry once per cycle unless stalled. Results
// addressed to R15 are steered to the separate PC write strobe instead of the
// register file port.
//
// Ports
//   clk                 rising-edge clock
//   reset               asynchronous, active-low reset
//   alu_valid/ready     ALU result handshake; alu_dest / alu_data payload
//   mem_valid/ready     load result handshake; mem_dest / mem_data payload
//   stall               holds the head entry and suppresses both write strobes
//   rf_write_enable     register file write strobe (head dest != 15)
//   rf_dest, rf_data    register file Destination_select / DATA
//   pc_write_enable     R15 write strobe (head dest == 15)
//   pc_data             value for R15
//   count               occupancy, 0..DEPTH
//   busy                occupancy is non-zero
//-----------------------------------------------------------------------------
`timescale 1ns/1ps
module writeback_queue #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     alu_valid,
   output logic                     alu_ready,
   input  logic [3:0]               alu_dest,
   input  logic [WIDTH-1:0]         alu_data,
   input  logic                     mem_valid,
   output logic                     mem_ready,
   input  logic [3:0]               mem_dest,
   input  logic [WIDTH-1:0]         mem_data,
   input  logic                     stall,
   output logic                     rf_write_enable,
   output logic [3:0]               rf_dest,
   output logic [WIDTH-1:0]         rf_data,
   output logic                     pc_write_enable,
   output logic [WIDTH-1:0]         pc_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     busy
);

   localparam int            AW       = $clog2(DEPTH);
   localparam int            CW       = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [3:0]    PC_REG   = 4'd15;

   // Entry storage is deliberately left unreset: every consumer of the head
   // entry is gated by the empty condition.
   logic [3:0]       dest_q [DEPTH];
   logic [WIDTH-1:0] data_q [DEPTH];

   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;

   logic             full, empty;
   logic             acc_mem, acc_alu, push, drain, head_is_pc;
   logic [3:0]       push_dest;
   logic [WIDTH-1:0] push_data;

   always_comb begin
      full      = (count_q == FULL_CNT);
      empty     = (count_q == '0);

      // Readies depend only on occupancy and mem_valid (never on stall), so
      // a full queue refuses new work even in a cycle where it drains. They
      // are also held low while reset is asserted.
      mem_ready = reset && !full;
      alu_ready = reset && !full && !mem_valid;

      acc_mem   = mem_valid && mem_ready;
      acc_alu   = alu_valid && alu_ready;
      push      = acc_mem || acc_alu;
      push_dest = acc_mem ? mem_dest : alu_dest;
      push_data = acc_mem ? mem_data : alu_data;

      drain      = !empty && !stall;
      head_is_pc = (dest_q[rd_ptr_q] == PC_REG);

      rf_dest         = dest_q[rd_ptr_q];
      rf_data         = data_q[rd_ptr_q];
      pc_data         = data_q[rd_ptr_q];
      rf_write_enable = drain && !head_is_pc;
      pc_write_enable = drain &&  head_is_pc;

      count = count_q;
      busy  = !empty;

      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (drain) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (push && !drain) begin
         count_d = count_q + CW'(1);
      end else if (drain && !push) begin
         count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         dest_q[wr_ptr_q] <= push_dest;
         data_q[wr_ptr_q] <= push_data;
      end
   end

endmodule

// File: tb/tb_writeback_queue.sv
`timescale 1ns/1ps
module tb_writeback_queue;

   logic        clk = 1'b0;
   logic        reset;
   logic        alu_valid, mem_valid, stall;
   logic        alu_ready, mem_ready;
   logic [3:0]  alu_dest, mem_dest, rf_dest;
   logic [31:0] alu_data, mem_data, rf_data, pc_data;
   logic        rf_write_enable, pc_write_enable, busy;
   logic [2:0]  count;

   int n_chk  = 0;
   int n_fail = 0;

   writeback_queue #(.WIDTH(32), .DEPTH(4)) dut (
      .clk             (clk),
      .reset           (reset),
      .alu_valid       (alu_valid),
      .alu_ready       (alu_ready),
      .alu_dest        (alu_dest),
      .alu_data        (alu_data),
      .mem_valid       (mem_valid),
      .mem_ready       (mem_ready),
      .mem_dest        (mem_dest),
      .mem_data        (mem_data),
      .stall           (stall),
      .rf_write_enable (rf_write_enable),
      .rf_dest         (rf_dest),
      .rf_data         (rf_data),
      .pc_write_enable (pc_write_enable),
      .pc_data         (pc_data),
      .count           (count),
      .busy            (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        av;
      logic [3:0]  ad;
      logic [31:0] adat;
      logic        mv;
      logic [3:0]  md;
      logic [31:0] mdat;
      logic        st;
      logic        ar;
      logic        mr;
      logic        rwe;
      logic        pwe;
      logic [3:0]  rd;
      logic [31:0] rdat;
      int          cnt;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic av, input logic [3:0] ad, input logic [31:0] adat,
                      input logic mv, input logic [3:0] md, input logic [31:0] mdat,
                      input logic st, input logic ar, input logic mr,
                      input logic rwe, input logic pwe, input logic [3:0] rd,
                      input logic [31:0] rdat, input int cnt);
      vec_t v;
      v.av = av; v.ad = ad; v.adat = adat;
      v.mv = mv; v.md = md; v.mdat = mdat; v.st = st;
      v.ar = ar; v.mr = mr; v.rwe = rwe; v.pwe = pwe;
      v.rd = rd; v.rdat = rdat; v.cnt = cnt;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      alu_valid = 1'b0; alu_dest = 4'd0; alu_data = 32'd0;
      mem_valid = 1'b0; mem_dest = 4'd0; mem_data = 32'd0;
      stall     = 1'b0;
   endtask

   int          exp_q[$];
   int          sent, got, cyc;
   int          exp_v;

   initial begin
      idle_inputs();
      reset = 1'b0;
      #2;
      chk("reset.count",     32'(count),           32'd0);
      chk("reset.busy",      32'(busy),            32'd0);
      chk("reset.rf_we",     32'(rf_write_enable), 32'd0);
      chk("reset.pc_we",     32'(pc_write_enable), 32'd0);
      chk("reset.alu_ready", 32'(alu_ready),       32'd0);
      chk("reset.mem_ready", 32'(mem_ready),       32'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("post_reset.alu_ready", 32'(alu_ready), 32'd1);
      chk("post_reset.mem_ready", 32'(mem_ready), 32'd1);

      // av ad adat  mv md mdat  st  ar mr rwe pwe rd rdat  cnt
      // single ALU write
      add(1, 3, 32'hDEADBEEF, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0);
      add(0, 0, 0,            0, 0, 0, 0,  1, 1, 1, 0, 3, 32'hDEADBEEF, 1);
      add(0, 0, 0,            0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0);
      // priority: mem wins, ALU accepted a cycle later
      add(1, 2, 32'h22,       1, 1, 32'h11, 0,  0, 1, 0, 0, 0, 0, 0);
      add(1, 2, 32'h22,       0, 0, 0,      0,  1, 1, 1, 0, 1, 32'h11, 1);
      add(0, 0, 0,            0, 0, 0,      0,  1, 1, 1, 0, 2, 32'h22, 1);
      add(0, 0, 0,            0, 0, 0,      0,  1, 1, 0, 0, 0, 0, 0);
      // fill under stall
      add(1, 4, 32'h10,       0, 0, 0, 1,  1, 1, 0, 0, 0, 0, 0);
      add(1, 5, 32'h11,       0, 0, 0, 1,  1, 1, 0, 0, 0, 0, 1);
      add(1, 6, 32'h12,       0, 0, 0, 1,  1, 1, 0, 0, 0, 0, 2);
      add(1, 7, 32'h13,       0, 0, 0, 1,  1, 1, 0, 0, 0, 0, 3);
      // full: an offered write must be refused, even while draining
      add(1, 9, 32'h99,       0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 4);
      add(1, 9, 32'h99,       0, 0, 0, 0,  0, 0, 1, 0, 4, 32'h10, 4);
      add(0, 0, 0,            0, 0, 0, 0,  1, 1, 1, 0, 5, 32'h11, 3);
      add(0, 0, 0,            0, 0, 0, 0,  1, 1, 1, 0, 6, 32'h12, 2);
      add(0, 0, 0,            0, 0, 0, 0,  1, 1, 1, 0, 7, 32'h13, 1);
      add(0, 0, 0,            0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0);
      // PC diversion
      add(0, 0, 0,            1, 15, 32'h100, 0,  0, 1, 0, 0, 0, 0, 0);
      add(0, 0, 0,            0, 0, 0,        0,  1, 1, 0, 1, 15, 32'h100, 1);
      add(0, 0, 0,            0, 0, 0,        0,  1, 1, 0, 0, 0, 0, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         alu_valid = vecs[i].av; alu_dest = vecs[i].ad; alu_data = vecs[i].adat;
         mem_valid = vecs[i].mv; mem_dest = vecs[i].md; mem_data = vecs[i].mdat;
         stall     = vecs[i].st;
         #2;
         chk($sformatf("row%0d.alu_ready", i), 32'(alu_ready),       32'(vecs[i].ar));
         chk($sformatf("row%0d.mem_ready", i), 32'(mem_ready),       32'(vecs[i].mr));
         chk($sformatf("row%0d.rf_we", i),     32'(rf_write_enable), 32'(vecs[i].rwe));
         chk($sformatf("row%0d.pc_we", i),     32'(pc_write_enable), 32'(vecs[i].pwe));
         chk($sformatf("row%0d.count", i),     32'(count),           32'(vecs[i].cnt));
         chk($sformatf("row%0d.busy", i),      32'(busy),            32'(vecs[i].cnt != 0));
         if (vecs[i].rwe || vecs[i].pwe) begin
            chk($sformatf("row%0d.rf_dest", i), 32'(rf_dest), 32'(vecs[i].rd));
            chk($sformatf("row%0d.rf_data", i), rf_data,      vecs[i].rdat);
         end
         if (vecs[i].pwe) begin
            chk($sformatf("row%0d.pc_data", i), pc_data, vecs[i].rdat);
         end
      end

      // Wrap-around: 10 ALU writes, stall toggling every cycle
      sent = 0; got = 0; cyc = 0;
      while (got < 10 && cyc < 200) begin
         @(negedge clk);
         idle_inputs();
         stall     = (cyc % 2) == 1;
         alu_valid = (sent < 10);
         alu_dest  = 4'd8;
         alu_data  = 32'(sent);
         #2;
         chk("wrap.count_le_depth", 32'(count <= 3'd4), 32'd1);
         if (pc_write_enable) chk("wrap.pc_we", 32'(pc_write_enable), 32'd0);
         if (rf_write_enable) begin
            if (exp_q.size() == 0) begin
               chk("wrap.unexpected_retire", 32'(rf_write_enable), 32'd0);
            end else begin
               exp_v = exp_q.pop_front();
               chk($sformatf("wrap.retire%0d", got), rf_data, 32'(exp_v));
               chk("wrap.dest", 32'(rf_dest), 32'd8);
            end
            got++;
         end
         if (alu_valid && alu_ready) begin
            exp_q.push_back(sent);
            sent++;
         end
         cyc++;
      end
      chk("wrap.all_retired", 32'(got), 32'd10);

      // Reset mid-operation with three queued entries
      @(negedge clk);
      idle_inputs();
      #2;
      chk("pre_rst.count", 32'(count), 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         stall = 1'b1;
         alu_valid = 1'b1; alu_dest = 4'd10; alu_data = 32'hA0 + 32'(i);
      end
      @(negedge clk);
      alu_valid = 1'b0;
      #2;
      chk("rst_mid.count_before", 32'(count), 32'd3);
      stall = 1'b0;
      #1;
      chk("rst_mid.rf_we_before", 32'(rf_write_enable), 32'd1);
      chk("rst_mid.rf_data_before", rf_data, 32'hA0);
      #1;
      reset = 1'b0;
      #1;
      chk("rst_mid.rf_we",     32'(rf_write_enable), 32'd0);
      chk("rst_mid.pc_we",     32'(pc_write_enable), 32'd0);
      chk("rst_mid.count",     32'(count),           32'd0);
      chk("rst_mid.busy",      32'(busy),            32'd0);
      chk("rst_mid.alu_ready", 32'(alu_ready),       32'd0);
      chk("rst_mid.mem_ready", 32'(mem_ready),       32'd0);
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         idle_inputs();
         #2;
         chk($sformatf("post_rst%0d.rf_we", i),     32'(rf_write_enable), 32'd0);
         chk($sformatf("post_rst%0d.pc_we", i),     32'(pc_write_enable), 32'd0);
         chk($sformatf("post_rst%0d.count", i),     32'(count),           32'd0);
         chk($sformatf("post_rst%0d.alu_ready", i), 32'(alu_ready),       32'd1);
         chk($sformatf("post_rst%0d.mem_ready", i), 32'(mem_ready),       32'd1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
